muldiv_iter_unit: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle integer ALU. Executes the RV32M/RV64M multiply/divide group (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for any XLEN.
- Uses an iterative radix-2 shift-add / restoring-shift-subtract datapath with valid/ready handshakes on both sides.
- Sits beside the ALU in the execute stage; the core stalls on in_ready/out_valid.

---
 rtl/muldiv_iter_unit.sv | 130 +++++++++++++
 tb/tb_muldiv_iter_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide with valid/ready handshakes on both sides; divide corner cases resolve at accept.
module muldiv_iter_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e              r_state;
  logic [2:0]          r_op;
  logic                r_neg;
  logic [XLEN-1:0]     r_a;
  logic [2*XLEN-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;

  logic                w_s1_signed, w_s2_signed, w_neg1, w_neg2, w_div0, w_ovf, w_special;
  logic [XLEN-1:0]     w_mag1, w_mag2, w_spec_res, w_fix_res, w_quo, w_rem;
  logic [XLEN:0]       w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod;

  // Operand decode at accept: magnitudes, result sign and divide corner cases.
  always_comb begin
    w_s2_signed = (op[2:1] == 2'b00) || (op[2] && !op[0]);
    w_s1_signed = w_s2_signed || (op == 3'b010);
    w_neg1      = w_s1_signed && src1[XLEN-1];
    w_neg2      = w_s2_signed && src2[XLEN-1];
    w_mag1      = w_neg1 ? -src1 : src1;
    w_mag2      = w_neg2 ? -src2 : src2;
    w_div0      = (src2 == '0);
    w_ovf       = op[2] && !op[0] && (src1 == MinNeg) && (src2 == '1);
    w_special   = op[2] && (w_div0 || w_ovf);
    if (op[1]) w_spec_res = w_div0 ? src1 : '0;
    else       w_spec_res = w_div0 ? '1 : MinNeg;
  end

  // One radix-2 step for each datapath; r_acc is {partial, multiplier} or {remainder, dividend}.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_mul_next = {w_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    w_diff     = w_rem_sh - {1'b0, r_a};
    if (w_diff[XLEN]) w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    else              w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_acc[XLEN-1:0];
    w_rem  = r_acc[2*XLEN-1:XLEN];
    unique case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = r_neg ? -w_quo : w_quo;
      default:                w_fix_res = r_neg ? -w_rem : w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_a      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid && in_ready) begin
            r_op  <= op;
            r_neg <= (op == 3'b110) ? w_neg1 : (w_neg1 ^ w_neg2);
            if (w_special) begin
              r_result <= w_spec_res;
              r_state  <= StDone;
            end else begin
              r_a     <= op[2] ? w_mag2 : w_mag1;
              r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_mag1 : w_mag2)};
              r_cnt   <= CNT_W'(XLEN);
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush) begin
            r_state <= StIdle;
          end else begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= StFix;
          end
        end
        StFix: begin
          if (flush) begin
            r_state <= StIdle;
          end else begin
            r_result <= w_fix_res;
            r_state  <= StDone;
          end
        end
        default: begin
          if (flush || out_ready) r_state <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (r_state == StIdle) && !flush;
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign result    = r_result;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit (XLEN=32 and XLEN=16 instances) against an arithmetic
// reference model, with a per-cycle result monitor.
module tb_muldiv_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] src1, src2, result;

  logic        flush_16, in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
  logic [2:0]  op_16;
  logic [15:0] src1_16, src2_16, result_16;

  muldiv_iter_unit #(.XLEN(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  muldiv_iter_unit #(.XLEN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flush(flush_16), .in_valid(in_valid_16),
    .in_ready(in_ready_16), .op(op_16), .src1(src1_16), .src2(src2_16),
    .out_valid(out_valid_16), .out_ready(out_ready_16), .result(result_16), .busy(busy_16)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_v32 = 1'b0;
  logic        exp_v16 = 1'b0;
  logic [31:0] exp_r32 = '0;
  logic [15:0] exp_r16 = '0;

  // RISC-V M semantics from plain wide arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a_in,
                                         input logic [63:0] b_in, input int xl);
    logic [127:0] mask, ua, ub, sa, sb, p;
    longint       sda, sdb;
    logic         ovf;
    logic [63:0]  r;
    mask = (128'd1 << xl) - 128'd1;
    ua   = {64'd0, a_in} & mask;
    ub   = {64'd0, b_in} & mask;
    sa   = ua[xl-1] ? (ua | ~mask) : ua;
    sb   = ub[xl-1] ? (ub | ~mask) : ub;
    sda  = longint'(sa[63:0]);
    sdb  = longint'(sb[63:0]);
    ovf  = (ua == (128'd1 << (xl - 1))) && (ub == mask);
    case (o)
      3'd0:    begin p = sa * sb;          r = p[63:0]; end
      3'd1:    begin p = (sa * sb) >> xl;  r = p[63:0]; end
      3'd2:    begin p = (sa * ub) >> xl;  r = p[63:0]; end
      3'd3:    begin p = (ua * ub) >> xl;  r = p[63:0]; end
      3'd4:    r = (ub == 0) ? '1 : ovf ? ua[63:0] : 64'(sda / sdb);
      3'd5:    begin p = (ub == 0) ? '1 : ua / ub; r = p[63:0]; end
      3'd6:    r = (ub == 0) ? ua[63:0] : ovf ? 64'd0 : 64'(sda % sdb);
      default: begin p = (ub == 0) ? ua : ua % ub; r = p[63:0]; end
    endcase
    return r & mask[63:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and check any presented result against the model.
  task automatic tick();
    @(negedge clk);
    if (out_valid) begin
      if (!exp_v32) check("spurious_valid32", 64'(out_valid), 64'd0);
      else          check("result32", 64'(result), 64'(exp_r32));
    end
    if (out_valid_16) begin
      if (!exp_v16) check("spurious_valid16", 64'(out_valid_16), 64'd0);
      else          check("result16", 64'(result_16), 64'(exp_r16));
    end
  endtask

  task automatic run(input bit w16, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] lit, input int exp_lat,
                     input string name);
    logic [63:0] m;
    int          lat;
    logic        got;
    m = ref_op(o, 64'(a), 64'(b), w16 ? 16 : 32);
    check({name, "_model"}, m, 64'(lit));
    if (w16) begin
      check({name, "_in_ready"}, 64'(in_ready_16), 64'd1);
      in_valid_16 = 1'b1; op_16 = o; src1_16 = a[15:0]; src2_16 = b[15:0];
      exp_r16 = m[15:0]; exp_v16 = 1'b1;
    end else begin
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1; op = o; src1 = a; src2 = b;
      exp_r32 = m[31:0]; exp_v32 = 1'b1;
    end
    tick();
    in_valid = 1'b0; in_valid_16 = 1'b0;
    src1 = $urandom; src2 = $urandom; op = 3'($urandom);
    src1_16 = 16'($urandom); src2_16 = 16'($urandom); op_16 = 3'($urandom);
    lat = 1;
    got = w16 ? out_valid_16 : out_valid;
    while (!got && lat < 100) begin
      check({name, "_busy"}, 64'(w16 ? busy_16 : busy), 64'd1);
      tick();
      lat++;
      got = w16 ? out_valid_16 : out_valid;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_result"}, w16 ? 64'(result_16) : 64'(result), 64'(lit));
  endtask

  // Consume the result (out_ready already high) and confirm return to idle.
  task automatic retire(input bit w16, input string name);
    exp_v32 = 1'b0; exp_v16 = 1'b0;
    tick();
    check({name, "_drop_valid"}, 64'(w16 ? out_valid_16 : out_valid), 64'd0);
    check({name, "_ready_again"}, 64'(w16 ? in_ready_16 : in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0; out_ready = 1'b1;
    flush_16 = 1'b0; in_valid_16 = 1'b0; op_16 = '0; src1_16 = '0; src2_16 = '0;
    out_ready_16 = 1'b1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_result16", 64'(result_16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    run(0, 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");       retire(0, "mul");
    run(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    retire(0, "mulh");
    run(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    retire(0, "mulhu");
    run(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    retire(0, "mulhsu");
    run(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div");        retire(0, "div");
    run(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem");        retire(0, "rem");
    run(0, 3'd5, 32'd100, 32'd7, 32'd14, 34, "divu");                    retire(0, "divu");
    run(0, 3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");                     retire(0, "remu");
    run(0, 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");            retire(0, "divu_by0");
    run(0, 3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_by0");                     retire(0, "rem_by0");
    run(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    retire(0, "div_ovf");
    run(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");     retire(0, "rem_ovf");

    // Backpressure: result held while out_ready is low; new requests ignored.
    out_ready = 1'b0;
    run(0, 3'd5, 32'd1000, 32'd3, 32'd333, 34, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); op = 3'd0; src1 = $urandom; src2 = $urandom;
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_v32 = 1'b0;
    tick();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_result", 64'(result), 64'd333);
    tick();
    check("bp_no_accept", 64'(busy), 64'd0);

    run(1, 3'd0, 32'h00FF, 32'h00FF, 32'hFE01, 18, "mul16");             retire(1, "mul16");
    run(1, 3'd4, 32'hFFF9, 32'd2, 32'hFFFD, 18, "div16");                retire(1, "div16");

    // Flush in CALC cycle 10: no result may ever appear.
    in_valid = 1'b1; op = 3'd5; src1 = 32'd1000; src2 = 32'd7;
    exp_v32 = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_idle", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    repeat (40) tick();
    run(0, 3'd7, 32'd1000, 32'd7, 32'd6, 34, "after_flush");             retire(0, "after_flush");

    // Asynchronous reset mid-CALC.
    in_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd5;
    exp_v32 = 1'b1; exp_r32 = 32'd15;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    exp_v32 = 1'b0;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_release_ready", 64'(in_ready), 64'd1);
    run(0, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 34, "after_rst");
    retire(0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
